// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared constants and FSM state type for the NoC master arbiter
package noc_pkg;

    localparam int NUM_PROC  = 4;
    localparam int PROC_ID_W = 2;
    localparam int FLIT_W    = 9;
    localparam int LAST_BIT  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } noc_state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - combinational 4-way round-robin selector
//
// Ports:
//   req[3:0]    request vector, bit i = processor i
//   ptr[1:0]    first processor examined; search continues ptr+1, ... mod 4
//   valid       at least one request present
//   winner[1:0] first requesting processor in search order
module rr_arbiter_4
    import noc_pkg::*;
(
    input  logic [NUM_PROC-1:0]  req,
    input  logic [PROC_ID_W-1:0] ptr,
    output logic                 valid,
    output logic [PROC_ID_W-1:0] winner
);

    logic [PROC_ID_W-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int i = 0; i < NUM_PROC; i++) begin
            // 2-bit add wraps 3 -> 0, giving the circular search order
            idx = ptr + i[PROC_ID_W-1:0];
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/noc_master.sv
// rtl/noc_master.sv - round-robin NoC ownership arbiter with transfer timeout
//
// Ports:
//   clock            single clock, rising edge
//   reset_n          asynchronous active-low reset
//   req[3:0]         per-processor transfer request
//   dest[7:0]        per-processor destination, dest[2i+1:2i] for processor i
//   last_flit[3:0]   per-processor last-flit marker (bit 8 of its flit)
//   master_response  one-hot grant acknowledge, high for the GRANT cycle only
//   grant_valid      high while a transfer owns the NoC (GRANT and XFER)
//   grant_src        granted processor, held until the next grant
//   grant_dst        captured destination, held until the next grant
//   timeout_err      one-cycle pulse in RELEASE after a forced release
//   self_err         sticky: an arbitration winner targeted itself
module noc_master
    import noc_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_PROC-1:0]           req,
    input  logic [NUM_PROC*PROC_ID_W-1:0] dest,
    input  logic [NUM_PROC-1:0]           last_flit,
    output logic [NUM_PROC-1:0]           master_response,
    output logic                          grant_valid,
    output logic [PROC_ID_W-1:0]          grant_src,
    output logic [PROC_ID_W-1:0]          grant_dst,
    output logic                          timeout_err,
    output logic                          self_err
);

    noc_state_t           state;
    noc_state_t           state_next;
    logic [PROC_ID_W-1:0] rr_ptr;
    logic [7:0]           tmo_cnt;
    logic                 tmo_flag;

    logic                 arb_valid;
    logic [PROC_ID_W-1:0] arb_winner;
    logic [PROC_ID_W-1:0] dest_sel;
    logic                 arb_take;
    logic                 self_hit;
    logic                 tmo_hit;

    rr_arbiter_4 u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    assign dest_sel = dest[{arb_winner, 1'b0} +: PROC_ID_W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        arb_take   = 1'b0;
        self_hit   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    // A self-addressed winner is refused but still consumes its turn
                    if (dest_sel == arb_winner) begin
                        self_hit = 1'b1;
                    end else begin
                        arb_take   = 1'b1;
                        state_next = GRANT;
                    end
                end
            end
            GRANT: begin
                state_next = XFER;
            end
            XFER: begin
                // Last flit has priority over a timeout landing on the same cycle
                if (last_flit[grant_src]) begin
                    state_next = RELEASE;
                end else if (tmo_cnt == TIMEOUT_CYCLES - 8'd1) begin
                    tmo_hit    = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            tmo_flag  <= 1'b0;
            grant_src <= '0;
            grant_dst <= '0;
            self_err  <= 1'b0;
        end else begin
            if (arb_take || self_hit) begin
                rr_ptr <= arb_winner + 2'd1;
            end
            if (arb_take) begin
                grant_src <= arb_winner;
                grant_dst <= dest_sel;
            end
            if (self_hit) begin
                self_err <= 1'b1;
            end
            // Registered so the pulse lines up with the RELEASE cycle
            tmo_flag <= tmo_hit;
            if (state == GRANT) begin
                tmo_cnt <= '0;
            end else if (state == XFER && tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    assign master_response = (state == GRANT) ? (4'b0001 << grant_src) : 4'b0000;
    assign grant_valid     = (state == GRANT) || (state == XFER);
    assign timeout_err     = tmo_flag;

endmodule

// File: tb/tb_noc_master.sv
// tb/tb_noc_master.sv - directed self-checking bench for noc_master
module tb_noc_master;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic [7:0] dest;
    logic [3:0] last_flit;
    logic [3:0] master_response;
    logic       grant_valid;
    logic [1:0] grant_src;
    logic [1:0] grant_dst;
    logic       timeout_err;
    logic       self_err;

    int errors = 0;
    int checks = 0;

    noc_master #(.TIMEOUT_CYCLES(8'd8)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req             (req),
        .dest            (dest),
        .last_flit       (last_flit),
        .master_response (master_response),
        .grant_valid     (grant_valid),
        .grant_src       (grant_src),
        .grant_dst       (grant_dst),
        .timeout_err     (timeout_err),
        .self_err        (self_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 4'b0; dest = 8'b0; last_flit = 4'b0;
        step(); step();
        checks++; if (master_response !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b expected 0000", master_response); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", grant_valid); end
        checks++; if ({grant_src, grant_dst} !== 4'b0) begin errors++; $display("FAIL reset_src_dst: got %b expected 0000", {grant_src, grant_dst}); end
        checks++; if ({timeout_err, self_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {timeout_err, self_err}); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
        reset_n = 1'b1;
        step();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", grant_valid); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_src;
        logic [3:0] exp_resp;
        logic [1:0] exp_dst;
        req  = 4'b1111;
        dest = 8'b00_11_10_01;
        for (int k = 0; k < 5; k++) begin
            exp_src  = 2'(k % 4);
            exp_resp = 4'b0001 << exp_src;
            exp_dst  = exp_src + 2'd1;
            step();
            checks++; if (master_response !== exp_resp) begin errors++; $display("FAIL fair_resp[%0d]: got %b expected %b", k, master_response, exp_resp); end
            checks++; if (grant_src !== exp_src || grant_dst !== exp_dst) begin errors++; $display("FAIL fair_src_dst[%0d]: got %0d/%0d expected %0d/%0d", k, grant_src, grant_dst, exp_src, exp_dst); end
            step();
            checks++; if (master_response !== 4'b0000 || grant_valid !== 1'b1) begin errors++; $display("FAIL fair_xfer[%0d]: got %b/%b expected 0000/1", k, master_response, grant_valid); end
            last_flit = exp_resp;
            step();
            last_flit = 4'b0;
            checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL fair_release[%0d]: got %b expected 0", k, grant_valid); end
            if (k == 4) req = 4'b0;
            step();
            checks++; if (grant_valid !== 1'b0 || master_response !== 4'b0000) begin errors++; $display("FAIL fair_idle[%0d]: got %b/%b expected 0/0000", k, grant_valid, master_response); end
        end
    endtask

    task automatic test_single();
        req  = 4'b0100;
        dest = 8'b00_01_00_00;
        step();
        checks++; if (master_response !== 4'b0100) begin errors++; $display("FAIL single_resp: got %b expected 0100", master_response); end
        checks++; if (grant_src !== 2'd2 || grant_dst !== 2'd1) begin errors++; $display("FAIL single_src_dst: got %0d/%0d expected 2/1", grant_src, grant_dst); end
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", grant_valid); end
        req  = 4'b1011;
        dest = 8'b11_11_11_11;
        step();
        checks++; if (master_response !== 4'b0000 || grant_valid !== 1'b1) begin errors++; $display("FAIL single_xfer: got %b/%b expected 0000/1", master_response, grant_valid); end
        step(); step(); step();
        checks++; if (grant_src !== 2'd2 || grant_dst !== 2'd1) begin errors++; $display("FAIL single_hold_xfer: got %0d/%0d expected 2/1", grant_src, grant_dst); end
        req = 4'b0;
        last_flit = 4'b0100;
        step();
        last_flit = 4'b0;
        checks++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL single_release: got %b/%b expected 0/0", grant_valid, timeout_err); end
        step();
        checks++; if (grant_src !== 2'd2 || grant_dst !== 2'd1) begin errors++; $display("FAIL single_hold_idle: got %0d/%0d expected 2/1", grant_src, grant_dst); end
        checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL single_rr_ptr: got %0d expected 3", dut.rr_ptr); end
    endtask

    task automatic test_spurious_last();
        req  = 4'b0001;
        dest = 8'b00_00_00_01;
        step();
        checks++; if (master_response !== 4'b0001 || grant_src !== 2'd0) begin errors++; $display("FAIL spur_grant: got %b/%0d expected 0001/0", master_response, grant_src); end
        req = 4'b0;
        step();
        last_flit = 4'b0010;
        step();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL spur_ignored1: got %b expected 1", grant_valid); end
        step();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL spur_ignored2: got %b expected 1", grant_valid); end
        last_flit = 4'b0001;
        step();
        last_flit = 4'b0;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL spur_release: got %b expected 0", grant_valid); end
        step();
    endtask

    task automatic test_self_dest();
        req  = 4'b0001;
        dest = 8'b00_00_00_00;
        step();
        req = 4'b0;
        checks++; if (master_response !== 4'b0000 || grant_valid !== 1'b0) begin errors++; $display("FAIL self_no_grant: got %b/%b expected 0000/0", master_response, grant_valid); end
        checks++; if (self_err !== 1'b1) begin errors++; $display("FAIL self_err_set: got %b expected 1", self_err); end
        checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL self_rr_ptr: got %0d expected 1", dut.rr_ptr); end
        step();
        checks++; if (self_err !== 1'b1) begin errors++; $display("FAIL self_err_sticky: got %b expected 1", self_err); end
        req  = 4'b0010;
        dest = 8'b00_00_11_00;
        step();
        req = 4'b0;
        checks++; if (master_response !== 4'b0010 || grant_src !== 2'd1 || grant_dst !== 2'd3) begin errors++; $display("FAIL self_then_grant: got %b/%0d/%0d expected 0010/1/3", master_response, grant_src, grant_dst); end
    endtask

    // Continues the grant to processor 1 left open by test_self_dest
    task automatic test_timeout();
        int early;
        early = 0;
        step();
        for (int i = 1; i <= 7; i++) begin
            step();
            if (grant_valid !== 1'b1 || timeout_err !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early: got %0d bad cycles expected 0", early); end
        step();
        checks++; if (timeout_err !== 1'b1 || grant_valid !== 1'b0) begin errors++; $display("FAIL tmo_release: got %b/%b expected 1/0", timeout_err, grant_valid); end
        step();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b expected 0", timeout_err); end
    endtask

    task automatic test_last_on_timeout();
        req  = 4'b0100;
        dest = 8'b00_11_00_00;
        step();
        req = 4'b0;
        checks++; if (grant_src !== 2'd2 || master_response !== 4'b0100) begin errors++; $display("FAIL lot_grant: got %0d/%b expected 2/0100", grant_src, master_response); end
        step();
        for (int i = 1; i <= 7; i++) step();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL lot_still_xfer: got %b expected 1", grant_valid); end
        last_flit = 4'b0100;
        step();
        last_flit = 4'b0;
        checks++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL lot_no_err: got %b/%b expected 0/0", grant_valid, timeout_err); end
        step();
    endtask

    task automatic test_reset_mid_xfer();
        req  = 4'b1000;
        dest = 8'b00_00_00_00;
        step();
        req = 4'b0;
        checks++; if (master_response !== 4'b1000 || grant_src !== 2'd3) begin errors++; $display("FAIL rst_pre_grant: got %b/%0d expected 1000/3", master_response, grant_src); end
        step(); step();
        reset_n = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0 || master_response !== 4'b0000) begin errors++; $display("FAIL rst_async_grant: got %b/%b expected 0/0000", grant_valid, master_response); end
        checks++; if ({grant_src, grant_dst, timeout_err, self_err} !== 6'b0) begin errors++; $display("FAIL rst_async_regs: got %b expected 000000", {grant_src, grant_dst, timeout_err, self_err}); end
        step(); step();
        checks++; if (dut.rr_ptr !== 2'd0 || grant_valid !== 1'b0) begin errors++; $display("FAIL rst_hold: got %0d/%b expected 0/0", dut.rr_ptr, grant_valid); end
        reset_n = 1'b1;
        req     = 4'b1000;
        step();
        req = 4'b0;
        checks++; if (master_response !== 4'b1000 || grant_src !== 2'd3 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_post_grant: got %b/%0d/%b expected 1000/3/0", master_response, grant_src, timeout_err); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL rst_post_ptr: got %0d expected 0", dut.rr_ptr); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_spurious_last();
        test_self_dest();
        test_timeout();
        test_last_on_timeout();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
